// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
//   SPI mode-0 peripheral with a small register bank. All logic runs on clk;
//   the SPI pins are asynchronous and pass through SYNC_STAGES-deep
//   synchronisers before any use.
//
//   Frame (MSB first): RW (1=write, 0=read), ADDR_W address bits, DATA_W data.
//   Writes commit only on chip-select release after exactly FRAME_W bits.
//   Reads return a snapshot of the addressed register on cipo, one bit per
//   falling sclk, starting right after the last address bit.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ncs        in   SPI chip select (active low, async)
//   sclk       in   SPI clock (async)
//   copi       in   SPI host->peripheral data (async)
//   cipo       out  SPI peripheral->host data
//   cipo_oe    out  pad enable for cipo, high while selected
//   regs_out   out  register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe  out  1-cycle pulse on bit k when reg k is written
//   frame_err  out  1-cycle pulse when a frame is discarded
//
// Handshake: there is no valid/ready flow control; the host owns timing and
// must hold sclk high and low for at least SYNC_STAGES+2 clk periods each.
// -----------------------------------------------------------------------------
module spi_reg_bank #(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ncs,
   input  logic                       sclk,
   input  logic                       copi,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       frame_err
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   // Counter must hold FRAME_W+1, the saturating overrun marker.
   localparam int CNT_W   = $clog2(FRAME_W + 2);

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_OVER = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0]  CNT_ADDR = CNT_W'(ADDR_W);
   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_REGS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Synchronisers: bit 0 is the first stage, bit SYNC_STAGES-1 the last.
   logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;

   state_t                            state_q, state_d;
   logic [FRAME_W-1:0]                shift_q, shift_d;
   logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]                 rd_q, rd_d;
   logic                              cipo_q, cipo_d;
   logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
   logic [NUM_REGS-1:0]               wr_strobe_q, wr_strobe_d;
   logic                              frame_err_q, frame_err_d;

   logic              ncs_s, copi_s;
   logic              ncs_rise, ncs_fall, sclk_rise, sclk_fall;
   logic              frame_rw;
   logic [ADDR_W-1:0] frame_addr;
   logic [DATA_W-1:0] frame_data;
   logic [ADDR_W-1:0] addr_now;
   logic [DATA_W-1:0] rd_lookup;

   assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   assign copi_s    = copi_sync_q[SYNC_STAGES-1];
   assign ncs_rise  =  ncs_sync_q[SYNC_STAGES-2]  & ~ncs_sync_q[SYNC_STAGES-1];
   assign ncs_fall  = ~ncs_sync_q[SYNC_STAGES-2]  &  ncs_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-2] &  sclk_sync_q[SYNC_STAGES-1];

   // Fields of a completed frame, valid when bit_cnt_q == FRAME_W.
   assign frame_rw   = shift_q[FRAME_W-1];
   assign frame_addr = shift_q[FRAME_W-2 -: ADDR_W];
   assign frame_data = shift_q[DATA_W-1:0];

   // Address as it will stand after the bit being shifted in now; used to
   // snapshot read data on the same edge that completes the address.
   assign addr_now = {shift_q[ADDR_W-2:0], copi_s};

   always_comb begin
      rd_lookup = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (addr_now == ADDR_W'(k)) rd_lookup = regs_q[k];
      end
   end

   always_comb begin
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};

      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      rd_d        = rd_q;
      cipo_d      = cipo_q;
      regs_d      = regs_q;
      wr_strobe_d = '0;
      frame_err_d = 1'b0;

      if (ncs_rise) begin
         // Deselect dominates any sclk edge in the same cycle.
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         cipo_d    = 1'b0;
         if (bit_cnt_q == CNT_FULL) begin
            if (frame_rw) begin
               if (frame_addr < ADDR_LIM) begin
                  for (int k = 0; k < NUM_REGS; k++) begin
                     if (frame_addr == ADDR_W'(k)) begin
                        regs_d[k]      = frame_data;
                        wr_strobe_d[k] = 1'b1;
                     end
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end else if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
         end
      end else if (ncs_fall) begin
         // Frame start; a coincident sclk edge is deliberately dropped.
         state_d   = ST_ADDR;
         shift_d   = '0;
         bit_cnt_d = '0;
         cipo_d    = 1'b0;
      end else if (!ncs_s && state_q != ST_IDLE) begin
         if (sclk_rise) begin
            if (bit_cnt_q < CNT_FULL) begin
               shift_d   = {shift_q[FRAME_W-2:0], copi_s};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (state_q == ST_ADDR && bit_cnt_q == CNT_ADDR) begin
                  state_d = ST_DATA;
                  rd_d    = rd_lookup;
               end
            end else begin
               bit_cnt_d = CNT_OVER;
            end
         end else if (sclk_fall && state_q == ST_DATA) begin
            cipo_d = rd_q[DATA_W-1];
            rd_d   = {rd_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs_sync_q  <= '1;
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         rd_q        <= '0;
         cipo_q      <= 1'b0;
         regs_q      <= '0;
         wr_strobe_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         ncs_sync_q  <= ncs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rd_q        <= rd_d;
         cipo_q      <= cipo_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign cipo      = cipo_q;
   assign cipo_oe   = ~ncs_s;
   assign regs_out  = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign frame_err = frame_err_q;

endmodule
